// File: rtl/round_robin_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grants.
// The requester granted most recently drops to lowest priority on the next cycle.
module round_robin_arbiter (
   input  logic clk,
   input  logic rst,
   input  logic req3,
   input  logic req2,
   input  logic req1,
   input  logic req0,
   output logic gnt3,
   output logic gnt2,
   output logic gnt1,
   output logic gnt0
);

   logic [1:0] r_ptr;
   logic [3:0] r_gnt;

   logic [3:0] w_req;
   logic       w_any;
   logic [1:0] w_win;
   logic [3:0] w_gnt_nxt;
   logic [1:0] w_ptr_nxt;

   assign w_req = {req3, req2, req1, req0};

   // Scan from the lowest-priority slot up, so the last hit is the highest-priority one.
   always_comb begin
      logic [1:0] v_idx;
      v_idx = 2'd0;
      w_any = 1'b0;
      w_win = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         v_idx = r_ptr + 2'(k);
         if (w_req[v_idx]) begin
            w_any = 1'b1;
            w_win = v_idx;
         end
      end
   end

   always_comb begin
      w_gnt_nxt = 4'b0000;
      w_ptr_nxt = r_ptr;
      if (w_any) begin
         w_gnt_nxt = 4'b0001 << w_win;
         w_ptr_nxt = w_win + 2'd1;
      end
   end

   // With no requests the pointer holds, so priority survives idle cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr <= 2'd0;
         r_gnt <= 4'b0000;
      end else begin
         r_ptr <= w_ptr_nxt;
         r_gnt <= w_gnt_nxt;
      end
   end

   assign {gnt3, gnt2, gnt1, gnt0} = r_gnt;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Directed bench for round_robin_arbiter: reset, contention, sole requester,
// rotation skip, pointer retention over idle cycles and mid-operation reset.
module tb_round_robin_arbiter;

   logic clk;
   logic rst;
   logic req3, req2, req1, req0;
   logic gnt3, gnt2, gnt1, gnt0;

   int n_assert = 0;
   int n_fail   = 0;

   round_robin_arbiter dut (
      .clk  (clk),
      .rst  (rst),
      .req3 (req3),
      .req2 (req2),
      .req1 (req1),
      .req0 (req0),
      .gnt3 (gnt3),
      .gnt2 (gnt2),
      .gnt1 (gnt1),
      .gnt0 (gnt0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] exp);
      logic [3:0] got;
      got = {gnt3, gnt2, gnt1, gnt0};
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: gnt=%b expected %b", tag, got, exp);
      end
      n_assert++;
      assert ($countones(got) <= 1) else begin
         n_fail++;
         $error("FAIL %s_onehot: gnt=%b expected at most one bit set", tag, got);
      end
   endtask

   // Drive requests away from the edge, then sample 1 time unit after it.
   task automatic step(input logic [3:0] req, input string tag, input logic [3:0] exp);
      @(negedge clk);
      {req3, req2, req1, req0} = req;
      @(posedge clk);
      #1;
      check(tag, exp);
   endtask

   initial begin
      rst = 1'b0;
      {req3, req2, req1, req0} = 4'b0000;
      #2;
      check("reset_async", 4'b0000);
      @(posedge clk); #1;
      check("reset_hold", 4'b0000);

      @(negedge clk) rst = 1'b1;
      step(4'b0000, "idle_0", 4'b0000);
      step(4'b0000, "idle_1", 4'b0000);

      step(4'b1111, "contend_0", 4'b0001);
      step(4'b1111, "contend_1", 4'b0010);
      step(4'b1111, "contend_2", 4'b0100);
      step(4'b1111, "contend_3", 4'b1000);
      step(4'b1111, "contend_wrap", 4'b0001);

      step(4'b0100, "sole2_0", 4'b0100);
      step(4'b0100, "sole2_1", 4'b0100);
      step(4'b0100, "sole2_2", 4'b0100);
      step(4'b0000, "sole2_drop", 4'b0000);

      step(4'b1001, "skip_to3", 4'b1000);
      step(4'b1001, "skip_to0", 4'b0001);

      step(4'b0010, "retain_g1", 4'b0010);
      step(4'b0000, "retain_idle0", 4'b0000);
      step(4'b0000, "retain_idle1", 4'b0000);
      step(4'b0101, "retain_g2", 4'b0100);

      step(4'b1000, "pre_reset_g3", 4'b1000);
      #2;
      rst = 1'b0;
      #1;
      check("midreset_async", 4'b0000);
      {req3, req2, req1, req0} = 4'b1111;
      @(posedge clk); #1;
      check("midreset_hold", 4'b0000);
      @(negedge clk);
      {req3, req2, req1, req0} = 4'b0000;
      rst = 1'b1;
      step(4'b0011, "post_reset_g0", 4'b0001);
      step(4'b0011, "post_reset_g1", 4'b0010);

      step(4'b1100, "wrap_g2", 4'b0100);
      step(4'b1100, "wrap_g3", 4'b1000);
      step(4'b1100, "wrap_again_g2", 4'b0100);
      step(4'b0000, "final_idle", 4'b0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/round_robin_arbiter.md
# round_robin_arbiter

Four-requester round-robin arbiter with registered, one-hot grants. Each cycle it grants at most one of `req0`–`req3`. Priority rotates so that the most recently granted requester becomes lowest priority, which guarantees starvation-free access to a shared resource such as a bus, memory port or shared FIFO. It is a leaf block clocked by the local system clock.

## Interface
- Parameters: none. Requester count is fixed at 4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `req3`  in  1  request from requester 3.
- `req2`  in  1  request from requester 2.
- `req1`  in  1  request from requester 1.
- `req0`  in  1  request from requester 0.
- `gnt3`  out  1  grant to requester 3 (registered).
- `gnt2`  out  1  grant to requester 2 (registered).
- `gnt1`  out  1  grant to requester 1 (registered).
- `gnt0`  out  1  grant to requester 0 (registered).
- Port order is exactly as listed (clk, rst, req3..req0, gnt3..gnt0). Instances connect positionally.

## Operation
- Internal state:
  - 2-bit priority pointer `ptr` (0..3), naming the highest-priority requester.
  - 4-bit grant register driving `gnt3..gnt0`.
- Arbitration, evaluated combinationally from current `req` and `ptr`:
  - Scan indices `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, each mod 4.
  - The first index with `req` = 1 wins.
- On each rising `clk` edge with `rst` = 1:
  - If any request is asserted: load a one-hot grant for the winner, and set `ptr` ← (winner + 1) mod 4.
  - If no request is asserted: grants ← 0000 and `ptr` is unchanged.
- Re-arbitration happens every cycle. There is no grant parking and no lock.
  - A requester that holds `req` is granted again only when no higher-priority (rotated) requester is asserting.
  - A sole requester is granted every cycle.
- Grant is not conditioned on the requester keeping `req` high after sampling. Grants reflect the requests present at the previous edge.
- Invariant: at most one of `gnt0..gnt3` is 1 at any time.
- Wrap-around: after a grant to 3, `ptr` = 0.

## Timing
- Latency is 1 cycle. Requests sampled at edge N appear as grants after edge N and are held until edge N+1.
- Dropping a request at edge N removes the grant after edge N (grant visible for that cycle only).
- Reset (`rst` = 0) acts asynchronously and immediately:
  - `gnt3..gnt0` = 0000.
  - `ptr` = 0, so `req0` has highest priority.
  - State holds while `rst` = 0, regardless of `clk`/`req`.
- Reset release: the first arbitration occurs at the first rising edge with `rst` = 1. The deassertion is assumed synchronous to `clk` by the system.
- Mid-operation reset clears the grants in the same cycle. Priority restarts from requester 0.
- Requests are synchronous to `clk`. No internal synchronizers.

## Test plan
- Reset then idle: `rst` = 0 → gnts 0000 immediately. Release with no requests → gnts stay 0000 for all cycles.
- Continuous contention: `req0..req3` all held at 1 from reset release → grants cycle gnt0, gnt1, gnt2, gnt3, gnt0, … one per cycle.
- Sole requester: only `req2` held 3 cycles → `gnt2` = 1 on each of the 3 cycles after sampling. Drop `req2` → 0000 on the next cycle.
- Rotation skip: after a grant to 2 (`ptr` = 3), assert `req0` and `req3` → `gnt3`. Next cycle, same requests → `gnt0`.
- Pointer retention across idle: grant 1, then 2 idle cycles (0000), then `req0` + `req2` → `gnt2` (`ptr` = 2 held through idle).
- Mid-operation reset: while `gnt3` = 1, pulse `rst` low → gnts 0000 without a clock edge. After release, `req1` + `req0` → `gnt0`.
